// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: nibble-serial wide subtractor controller.
// A WIDTH-bit request (a - b - bin) is computed one nibble per cycle on a
// shared 4-bit ripple-borrow stage, with the borrow carried in borrow_r
// between nibbles. The result is returned over a valid/ready handshake.
// Optional feature macro: SUB_OVF_EN adds the signed-overflow output ovf.
module serial_sub_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             borrow_r;
  logic [CW-1:0]    cnt;
  logic [4:0]       stage;
  logic             last_nib;

  // 4-bit ripple-borrow subtract: returns {borrow_out, difference[3:0]}.
  function automatic logic [4:0] nib_sub(input logic [3:0] x,
                                         input logic [3:0] y,
                                         input logic       bi);
    nib_sub = {1'b0, x} - {1'b0, y} - {4'b0000, bi};
  endfunction

`ifdef SUB_OVF_EN
  // Signed overflow of the top nibble: borrow into bit 3 XOR borrow out.
  // Borrow into bit 3 is recovered from the bit-3 sum: d3 = x3 ^ y3 ^ bi3.
  function automatic logic msb_ovf(input logic [3:0] x,
                                   input logic [3:0] y,
                                   input logic [4:0] r);
    msb_ovf = (x[3] ^ y[3] ^ r[3]) ^ r[4];
  endfunction
`endif

  // Shared nibble stage fed from the low nibble of the operand shifters.
  always_comb begin
    stage    = nib_sub(a_sr[3:0], b_sr[3:0], borrow_r);
    last_nib = (cnt == CW'(NIB - 1));
  end

  // Handshake and status decoded purely from the state register.
  assign start_ready = (state == IDLE) && !rst;
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);

  // Controller FSM with operand shifters, borrow register and result regs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      borrow_r <= 1'b0;
      cnt      <= '0;
      diff     <= '0;
      bout     <= 1'b0;
`ifdef SUB_OVF_EN
      ovf      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            borrow_r <= bin;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          // New nibble enters at the top so the first one ends at the bottom.
          diff     <= {stage[3:0], diff[WIDTH-1:4]};
          a_sr     <= a_sr >> 4;
          b_sr     <= b_sr >> 4;
          borrow_r <= stage[4];
          cnt      <= cnt + CW'(1);
          if (last_nib) begin
            bout  <= stage[4];
`ifdef SUB_OVF_EN
            ovf   <= msb_ovf(a_sr[3:0], b_sr[3:0], stage);
`endif
            state <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Testbench for serial_sub_ctrl (WIDTH=16): directed scenarios plus
// randomized requests checked against an arithmetic reference model.
module tb_serial_sub_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .bin         (bin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .diff        (diff),
    .bout        (bout),
    .busy        (busy)
`ifdef SUB_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {borrow_out, difference} from plain integer arithmetic.
  function automatic logic [W:0] model_sub(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mbin);
    longint r;
    logic [W-1:0] d;
    r = longint'(ma) - longint'(mb) - longint'(mbin);
    d = r[W-1:0];
    model_sub = {(r < 0), d};
  endfunction

`ifdef SUB_OVF_EN
  function automatic logic model_ovf(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                     input logic mbin);
    longint sr;
    longint lim;
    lim = longint'(1) << (W - 1);
    sr  = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mbin);
    model_ovf = (sr < -lim) || (sr > lim - 1);
  endfunction
`endif

  // Present a request in IDLE and let it be accepted on the next edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start_valid = 1'b1;
    check("start_ready_idle", 64'(start_ready), 64'(1));
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    bin = 1'($urandom);
  endtask

  // Called just after the accept edge; checks latency and the result in DONE.
  task automatic expect_result(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
    logic [W:0] e;
    e = model_sub(ta, tb_, tbin);
    repeat (NIB - 1) @(posedge clk);
    @(negedge clk);
    check("res_valid_early", 64'(res_valid), 64'(0));
    check("busy_run", 64'(busy), 64'(1));
    check("start_ready_run", 64'(start_ready), 64'(0));
    @(negedge clk);
    check("res_valid_lat", 64'(res_valid), 64'(1));
    check("diff", 64'(diff), 64'(e[W-1:0]));
    check("bout", 64'(bout), 64'(e[W]));
    check("start_ready_done", 64'(start_ready), 64'(0));
`ifdef SUB_OVF_EN
    check("ovf", 64'(ovf), 64'(model_ovf(ta, tb_, tbin)));
`endif
  endtask

  // Complete the result handshake and confirm the IDLE bubble.
  task automatic release_result();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("res_valid_after_hs", 64'(res_valid), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
    check("start_ready_after_hs", 64'(start_ready), 64'(1));
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
    start_op(ta, tb_, tbin);
    expect_result(ta, tb_, tbin);
    release_result();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] held_diff;
    logic         held_bout;
    int           n;
    int           rc [2];
    logic [W-1:0] rd [2];
    logic         rb [2];
    logic [W-1:0] ra;
    logic [W-1:0] rbv;

    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_diff", 64'(diff), 64'(0));
    check("rst_bout", 64'(bout), 64'(0));
    check("rst_start_ready", 64'(start_ready), 64'(0));
`ifdef SUB_OVF_EN
    check("rst_ovf", 64'(ovf), 64'(0));
`endif
    rst = 1'b0;
    #1;
    check("start_ready_post_rst", 64'(start_ready), 64'(1));

    // Directed: simple subtract, exact latency
    start_op(16'h1234, 16'h0234, 1'b0);
    expect_result(16'h1234, 16'h0234, 1'b0);
    check("d1_diff", 64'(diff), 64'h1000);
    check("d1_bout", 64'(bout), 64'(0));
    release_result();

    // Directed: borrow ripples through every nibble
    start_op(16'h0000, 16'h0001, 1'b0);
    expect_result(16'h0000, 16'h0001, 1'b0);
    check("d2_diff", 64'(diff), 64'hFFFF);
    check("d2_bout", 64'(bout), 64'(1));
    release_result();

`ifdef SUB_OVF_EN
    start_op(16'h8000, 16'h0001, 1'b0);
    expect_result(16'h8000, 16'h0001, 1'b0);
    check("o1_diff", 64'(diff), 64'h7FFF);
    check("o1_ovf", 64'(ovf), 64'(1));
    release_result();
    start_op(16'h7FFF, 16'hFFFF, 1'b1);
    expect_result(16'h7FFF, 16'hFFFF, 1'b1);
    check("o2_diff", 64'(diff), 64'h7FFF);
    check("o2_ovf", 64'(ovf), 64'(0));
    release_result();
`endif

    // Backpressure with a concurrent request held on start_valid
    start_op(16'hA5A5, 16'h1234, 1'b0);
    expect_result(16'hA5A5, 16'h1234, 1'b0);
    held_diff = diff;
    held_bout = bout;
    ra = 16'h0F0F; rbv = 16'h0101;
    a = ra; b = rbv; bin = 1'b1; start_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_res_valid", 64'(res_valid), 64'(1));
      check("bp_diff", 64'(diff), 64'(held_diff));
      check("bp_bout", 64'(bout), 64'(held_bout));
      check("bp_start_ready", 64'(start_ready), 64'(0));
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_ready", 64'(start_ready), 64'(1));
    check("bp_idle_valid", 64'(res_valid), 64'(0));
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    expect_result(ra, rbv, 1'b1);
    release_result();

    // Reset during the second RUN cycle
    start_op(16'h4321, 16'h1111, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mr_res_valid", 64'(res_valid), 64'(0));
    check("mr_busy", 64'(busy), 64'(0));
    check("mr_diff", 64'(diff), 64'(0));
    check("mr_bout", 64'(bout), 64'(0));
    check("mr_start_ready_rst", 64'(start_ready), 64'(0));
    rst = 1'b0;
    #1;
    check("mr_start_ready", 64'(start_ready), 64'(1));
    start_op(16'h00FF, 16'h000F, 1'b0);
    expect_result(16'h00FF, 16'h000F, 1'b0);
    check("mr_after_diff", 64'(diff), 64'h00F0);
    release_result();

    // Back-to-back with start_valid and res_ready held high
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; bin = 1'b1; start_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk);
    #1;
    a = 16'h0010; b = 16'h0001; bin = 1'b0;
    n = 0;
    for (int cyc = 1; cyc <= 30 && n < 2; cyc++) begin
      @(negedge clk);
      if (res_valid) begin
        rc[n] = cyc; rd[n] = diff; rb[n] = bout;
        n++;
      end
    end
    start_valid = 1'b0;
    check("b2b_count", 64'(n), 64'(2));
    if (n == 2) begin
      check("b2b_first_lat", 64'(rc[0]), 64'(NIB + 1));
      check("b2b_diff0", 64'(rd[0]), 64'hFFFF);
      check("b2b_bout0", 64'(rb[0]), 64'(1));
      check("b2b_diff1", 64'(rd[1]), 64'h000F);
      check("b2b_bout1", 64'(rb[1]), 64'(0));
      check("b2b_spacing", 64'(rc[1] - rc[0]), 64'(NIB + 2));
    end
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("b2b_idle", 64'(start_ready), 64'(1));

    // Boundary and randomized requests
    run_op(16'hFFFF, 16'h0000, 1'b1);
    run_op(16'h0000, 16'hFFFF, 1'b1);
    run_op(16'h8000, 16'h8000, 1'b0);
    for (int i = 0; i < 25; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
